axilite_reg_slave: RTL and testbench

- AXI-Lite responder (slave end) fronting a bank of NUM_REGS software-visible 32-bit control/status registers.
- Accepts AW and W independently, commits writes, returns B responses, and services AR/R reads.
- Sits on an axilite_int#(32,9) link, opposite an AXI-Lite master such as the core's memory driver wrapper.
- Register contents drive peripheral control; selected registers are hardware-owned, read-only status.

---
 rtl/axilite_pkg.sv | 14 +
 rtl/axilite_reg_decode.sv | 34 +++
 rtl/axilite_reg_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_axilite_reg_slave.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_pkg.sv
// Shared types and constants for the AXI-Lite register slave.
// Response codes, channel FSM state encodings and the fixed data width.
package axilite_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

endpackage

// File: rtl/axilite_reg_decode.sv
// Combinational byte-address decode into a word index plus range and read-only flags.
// One instance serves the write address path, another the read address path.
import axilite_pkg::*;

module axilite_reg_decode #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-3:0] index,
  output logic                  in_range,
  output logic                  read_only
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  // Byte-lane bits carry no meaning for whole-word registers.
  logic unused_byte_lane;
  assign unused_byte_lane = ^addr[1:0];

  assign index    = addr[ADDR_WIDTH-1:2];
  assign in_range = int'(index) < NUM_REGS;

  always_comb begin
    read_only = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (index == IDX_W'(i)) begin
        read_only = RO_MASK[i];
      end
    end
  end

endmodule

// File: rtl/axilite_reg_slave.sv
// AXI-Lite slave fronting a bank of 32-bit control/status registers.
// Independent write (AW+W -> B) and read (AR -> R) channels, each one transaction deep.
import axilite_pkg::*;

module axilite_reg_slave #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           AXI_ACLK,
  input  logic                           AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AXI_AWADDR,
  input  logic                           AXI_AWVALID,
  output logic                           AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          AXI_WDATA,
  input  logic                           AXI_WVALID,
  output logic                           AXI_WREADY,
  output logic [1:0]                     AXI_BRESP,
  output logic                           AXI_BVALID,
  input  logic                           AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          AXI_ARADDR,
  input  logic                           AXI_ARVALID,
  output logic                           AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          AXI_RDATA,
  output logic [1:0]                     AXI_RRESP,
  output logic                           AXI_RVALID,
  input  logic                           AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] sts_in
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic aw_ready, aw_ready_next;
  logic w_ready, w_ready_next;
  logic aw_held, aw_held_next;
  logic w_held, w_held_next;
  logic bvalid, bvalid_next;
  resp_t bresp, bresp_next;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;

  logic ar_ready, ar_ready_next;
  logic rvalid, rvalid_next;
  resp_t rresp, rresp_next;
  logic [DATA_WIDTH-1:0] rdata, rdata_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic wr_in_range, wr_read_only, rd_in_range, rd_read_only;

  assign aw_hs = AXI_AWVALID && aw_ready;
  assign w_hs  = AXI_WVALID && w_ready;
  assign ar_hs = AXI_ARVALID && ar_ready;

  // A held half takes priority; otherwise the live bus value is the one handshaking now.
  assign wr_addr = aw_held ? aw_addr_q : AXI_AWADDR;
  assign wr_data = w_held ? w_data_q : AXI_WDATA;
  assign commit  = (wr_state == WR_IDLE) && (aw_hs || aw_held) && (w_hs || w_held);
  assign wr_ok   = wr_in_range && !wr_read_only;

  axilite_reg_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK)
  ) u_wr_decode (
    .addr     (wr_addr),
    .index    (wr_idx),
    .in_range (wr_in_range),
    .read_only(wr_read_only)
  );

  axilite_reg_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK)
  ) u_rd_decode (
    .addr     (AXI_ARADDR),
    .index    (rd_idx),
    .in_range (rd_in_range),
    .read_only(rd_read_only)
  );

  always_comb begin
    wr_state_next = wr_state;
    aw_ready_next = aw_ready;
    w_ready_next  = w_ready;
    aw_held_next  = aw_held;
    w_held_next   = w_held;
    bvalid_next   = bvalid;
    bresp_next    = bresp;
    case (wr_state)
      WR_IDLE: begin
        if (commit) begin
          wr_state_next = WR_RESP;
          bvalid_next   = 1'b1;
          bresp_next    = wr_ok ? RESP_OKAY : RESP_SLVERR;
          aw_ready_next = 1'b0;
          w_ready_next  = 1'b0;
          aw_held_next  = 1'b0;
          w_held_next   = 1'b0;
        end else begin
          aw_held_next  = aw_held || aw_hs;
          w_held_next   = w_held || w_hs;
          aw_ready_next = !(aw_held || aw_hs);
          w_ready_next  = !(w_held || w_hs);
        end
      end
      WR_RESP: begin
        if (AXI_BREADY) begin
          wr_state_next = WR_IDLE;
          bvalid_next   = 1'b0;
          aw_ready_next = 1'b1;
          w_ready_next  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_word = rd_read_only ? sts_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  always_comb begin
    rd_state_next = rd_state;
    ar_ready_next = ar_ready;
    rvalid_next   = rvalid;
    rresp_next    = rresp;
    rdata_next    = rdata;
    case (rd_state)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_next = RD_RESP;
          ar_ready_next = 1'b0;
          rvalid_next   = 1'b1;
          rdata_next    = rd_in_range ? rd_word : '0;
          rresp_next    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          ar_ready_next = 1'b1;
        end
      end
      RD_RESP: begin
        if (AXI_RREADY) begin
          rd_state_next = RD_IDLE;
          rvalid_next   = 1'b0;
          ar_ready_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      wr_state  <= WR_IDLE;
      aw_ready  <= 1'b0;
      w_ready   <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      wr_state  <= wr_state_next;
      aw_ready  <= aw_ready_next;
      w_ready   <= w_ready_next;
      aw_held   <= aw_held_next;
      w_held    <= w_held_next;
      bvalid    <= bvalid_next;
      bresp     <= bresp_next;
      if (aw_hs) aw_addr_q <= AXI_AWADDR;
      if (w_hs) w_data_q <= AXI_WDATA;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      rd_state <= RD_IDLE;
      ar_ready <= 1'b0;
      rvalid   <= 1'b0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
    end else begin
      rd_state <= rd_state_next;
      ar_ready <= ar_ready_next;
      rvalid   <= rvalid_next;
      rresp    <= rresp_next;
      rdata    <= rdata_next;
    end
  end

  // Rejected writes (out of range or read-only) leave the bank and strobes untouched.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_ok && wr_idx == IDX_W'(i)) begin
          regs[i]       <= wr_data;
          wr_pulse_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  assign AXI_AWREADY = aw_ready;
  assign AXI_WREADY  = w_ready;
  assign AXI_BVALID  = bvalid;
  assign AXI_BRESP   = bresp;
  assign AXI_ARREADY = ar_ready;
  assign AXI_RVALID  = rvalid;
  assign AXI_RRESP   = rresp;
  assign AXI_RDATA   = rdata;
  assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_axilite_reg_slave.sv
// Self-checking bench for axilite_reg_slave: directed scenarios plus randomized traffic
// compared against an address-rule register model.
module tb_axilite_reg_slave;

  localparam int AW = 9;
  localparam int NR = 16;
  localparam logic [NR-1:0] TB_RO = 16'h0002;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [NR*32-1:0] reg_out, sts_in;
  logic [NR-1:0] wr_pulse;

  logic [31:0] sts_words [NR];
  logic [31:0] model_regs [NR];
  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  always_comb begin
    sts_in = '0;
    for (int i = 0; i < NR; i++) sts_in[i*32 +: 32] = sts_words[i];
  end

  axilite_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(TB_RO)) dut (
    .AXI_ACLK(aclk), .AXI_ARESETN(aresetn),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .sts_in(sts_in)
  );

  function automatic bit model_write_ok(input logic [AW-1:0] a);
    int idx = int'(a) / 4;
    if (idx >= NR) return 1'b0;
    return !TB_RO[idx];
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int idx = int'(a) / 4;
    if (idx >= NR) return 32'h0;
    return TB_RO[idx] ? sts_words[idx] : model_regs[idx];
  endfunction

  function automatic logic [1:0] model_rresp(input logic [AW-1:0] a);
    return (int'(a) / 4 < NR) ? OKAY : SLVERR;
  endfunction

  function automatic logic [NR-1:0] model_pulse(input logic [AW-1:0] a);
    logic [NR-1:0] p = '0;
    if (model_write_ok(a)) p[int'(a) / 4] = 1'b1;
    return p;
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f = '0;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d);
    if (model_write_ok(a)) model_regs[int'(a) / 4] = d;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output logic [NR-1:0] pulse, output bit to);
    bit aw_done, w_done;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      @(posedge aclk); #1; n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    while (!bvalid && n < 40) begin
      @(posedge aclk); #1; n++;
    end
    to = !bvalid;
    resp = bresp;
    pulse = wr_pulse;
    @(posedge aclk); #1;
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit to);
    bit ar_done;
    int n;
    ar_done = 1'b0; n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!ar_done && n < 20) begin
      if (arvalid && arready) ar_done = 1'b1;
      @(posedge aclk); #1; n++;
      if (ar_done) arvalid = 1'b0;
    end
    while (!rvalid && n < 40) begin
      @(posedge aclk); #1; n++;
    end
    to = !rvalid;
    d = rdata;
    resp = rresp;
    @(posedge aclk); #1;
    rready = 1'b0; arvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_handshake: got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      bad++; $display("[TB] FAIL reset_resp: got %h want 0", {bresp, rresp, rdata});
    end
    total++;
    if (reg_out !== '0 || wr_pulse !== '0) begin
      bad++; $display("[TB] FAIL reset_regs: got pulse %h regs %h want 0", wr_pulse, reg_out);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("[TB] FAIL reset_release_ready: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic_write_read();
    logic [31:0] d;
    logic [1:0] r;
    bit to;
    awaddr = 9'h000; wdata = 32'hDEADBEEF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(9'h000, 32'hDEADBEEF);
    total++;
    if (bvalid !== 1'b1 || bresp !== OKAY) begin
      bad++; $display("[TB] FAIL basic_bresp: got valid %b resp %b want 1 00", bvalid, bresp);
    end
    total++;
    if (reg_out[31:0] !== 32'hDEADBEEF || wr_pulse !== 16'h0001) begin
      bad++; $display("[TB] FAIL basic_commit: got reg %h pulse %h want deadbeef 0001", reg_out[31:0], wr_pulse);
    end
    @(posedge aclk); #1;
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0 || wr_pulse !== '0 || {awready, wready} !== 2'b11) begin
      bad++; $display("[TB] FAIL basic_b_done: got bvalid %b pulse %h rdy %b want 0 0000 11", bvalid, wr_pulse, {awready, wready});
    end
    axi_read(9'h000, d, r, to);
    total++;
    if (to || d !== 32'hDEADBEEF || r !== OKAY) begin
      bad++; $display("[TB] FAIL basic_readback: got %h/%b to=%0d want deadbeef/00", d, r, to);
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h12345678; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    repeat (3) begin
      total++;
      if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
        bad++; $display("[TB] FAIL w_early_wait: got wready %b bvalid %b awready %b want 0 0 1", wready, bvalid, awready);
      end
      @(posedge aclk); #1;
    end
    awaddr = 9'h00C; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    model_write(9'h00C, 32'h12345678);
    total++;
    if (bvalid !== 1'b1 || bresp !== OKAY || reg_out[127:96] !== 32'h12345678 || wr_pulse !== 16'h0008) begin
      bad++; $display("[TB] FAIL w_early_commit: got bvalid %b resp %b reg3 %h pulse %h want 1 00 12345678 0008",
                      bvalid, bresp, reg_out[127:96], wr_pulse);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [1:0] r;
    logic [NR-1:0] p;
    logic [31:0] d;
    bit to;
    axi_write(9'h1FC, $urandom, r, p, to);
    total++;
    if (to || r !== SLVERR || p !== '0 || reg_out !== model_flat()) begin
      bad++; $display("[TB] FAIL oor_write: got resp %b pulse %h to=%0d regs_ok=%0d want 10 0000", r, p, to, reg_out === model_flat());
    end
    axi_read(9'h1FC, d, r, to);
    total++;
    if (to || d !== 32'h0 || r !== SLVERR) begin
      bad++; $display("[TB] FAIL oor_read: got %h/%b want 00000000/10", d, r);
    end
    // Word index 64 lies past the 16-register bank.
    axi_write(9'h100, 32'hDEADBEEF, r, p, to);
    total++;
    if (to || r !== (model_write_ok(9'h100) ? OKAY : SLVERR) || reg_out !== model_flat()) begin
      bad++; $display("[TB] FAIL oor_write_100: got resp %b want %b", r, model_write_ok(9'h100) ? OKAY : SLVERR);
    end
  endtask

  task automatic test_read_only();
    logic [1:0] r;
    logic [NR-1:0] p;
    logic [31:0] d;
    bit to;
    sts_words[1] = 32'hA5A5A5A5;
    axi_read(9'h004, d, r, to);
    total++;
    if (to || d !== 32'hA5A5A5A5 || r !== OKAY) begin
      bad++; $display("[TB] FAIL ro_read: got %h/%b want a5a5a5a5/00", d, r);
    end
    axi_write(9'h004, 32'h0BADF00D, r, p, to);
    total++;
    if (to || r !== SLVERR || p !== '0 || reg_out[63:32] !== 32'h0) begin
      bad++; $display("[TB] FAIL ro_write: got resp %b pulse %h reg1 %h want 10 0000 00000000", r, p, reg_out[63:32]);
    end
  endtask

  task automatic test_bready_stall();
    logic [31:0] d;
    d = $urandom;
    awaddr = 9'h014; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(9'h014, d);
    repeat (5) begin
      total++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, OKAY, 2'b00}) begin
        bad++; $display("[TB] FAIL stall_hold: got %b want 10000", {bvalid, bresp, awready, wready});
      end
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    total++;
    if ({bvalid, awready, wready} !== 3'b011 || reg_out !== model_flat()) begin
      bad++; $display("[TB] FAIL stall_release: got %b want 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_val, new_val;
    logic [1:0] r;
    logic [31:0] d;
    bit to;
    old_val = model_read(9'h01C);
    new_val = ~old_val ^ 32'h5A5A0F0F;
    awaddr = 9'h01C; wdata = new_val; araddr = 9'h01C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(9'h01C, new_val);
    total++;
    if (rvalid !== 1'b1 || rdata !== old_val || reg_out[255:224] !== new_val) begin
      bad++; $display("[TB] FAIL same_edge: got rvalid %b rdata %h reg7 %h want 1 %h %h", rvalid, rdata, reg_out[255:224], old_val, new_val);
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_read(9'h01C, d, r, to);
    total++;
    if (to || d !== new_val || r !== OKAY) begin
      bad++; $display("[TB] FAIL same_edge_readback: got %h/%b want %h/00", d, r, new_val);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [31:0] d, exp_d;
    logic [1:0] r, exp_r;
    logic [NR-1:0] p, exp_p;
    bit to;
    for (int k = 0; k < 60; k++) begin
      a = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) sts_words[$urandom_range(0, NR-1)] = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        exp_r = model_write_ok(a) ? OKAY : SLVERR;
        exp_p = model_pulse(a);
        model_write(a, d);
        axi_write(a, d, r, p, to);
        total++;
        if (to || r !== exp_r || p !== exp_p || reg_out !== model_flat()) begin
          bad++; $display("[TB] FAIL rand_write a=%h: got resp %b pulse %h to=%0d want %b %h regs_ok=%0d",
                          a, r, p, to, exp_r, exp_p, reg_out === model_flat());
        end
      end else begin
        exp_d = model_read(a);
        exp_r = model_rresp(a);
        axi_read(a, d, r, to);
        total++;
        if (to || d !== exp_d || r !== exp_r) begin
          bad++; $display("[TB] FAIL rand_read a=%h: got %h/%b to=%0d want %h/%b", a, d, r, to, exp_d, exp_r);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    araddr = 9'h000; arvalid = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    awaddr = 9'h008; awvalid = 1'b1; wvalid = 1'b0;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    total++;
    if ({rvalid, awready, wready} !== 3'b101) begin
      bad++; $display("[TB] FAIL midflight_setup: got %b want 101", {rvalid, awready, wready});
    end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || reg_out !== '0 || wr_pulse !== '0) begin
      bad++; $display("[TB] FAIL midflight_reset: got %b regs_zero=%0d want 00000", {awready, wready, arready, bvalid, rvalid}, reg_out === '0);
    end
    aresetn = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("[TB] FAIL midflight_release: got %b want 111", {awready, wready, arready});
    end
    // A W alone must not pair with the AW that was dropped by reset.
    wdata = 32'hCAFEF00D; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    repeat (5) begin
      total++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
        bad++; $display("[TB] FAIL midflight_stale: got bvalid %b rvalid %b want 0 0", bvalid, rvalid);
      end
      @(posedge aclk); #1;
    end
    awaddr = 9'h008; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    model_write(9'h008, 32'hCAFEF00D);
    total++;
    if (bvalid !== 1'b1 || wr_pulse !== 16'h0004 || reg_out !== model_flat()) begin
      bad++; $display("[TB] FAIL midflight_resume: got bvalid %b pulse %h reg2 %h want 1 0004 cafef00d", bvalid, wr_pulse, reg_out[95:64]);
    end
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      sts_words[i] = $urandom;
      model_regs[i] = 32'h0;
    end
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_out_of_range();
    test_read_only();
    test_bready_stall();
    test_same_edge();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
